umtrx_tx_dac_mux: RTL and testbench



---
 rtl/umtrx_tx_dac_mux_if.sv | 30 +++
 rtl/umtrx_tx_dac_mux.sv | 143 ++++++++++++++
 tb/tb_umtrx_tx_dac_mux.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/umtrx_tx_dac_mux_if.sv
// Deframer-to-DAC bus bundle: settings writes, DAC strobe, channel samples/flags in; strobes and DAC words out.
// Purely combinational wiring; no flow control beyond the per-channel consume strobes.
interface umtrx_tx_dac_mux_if #(
    parameter int NUM_CHAN   = 2,
    parameter int NUM_DAC    = 2,
    parameter int SAMP_WIDTH = 16,
    parameter int DAC_WIDTH  = 12
);
    logic                               set_stb;
    logic [7:0]                         set_addr;
    logic [31:0]                        set_data;
    logic                               dac_stb;
    logic [NUM_CHAN*2*SAMP_WIDTH-1:0]   chan_sample;
    logic [NUM_CHAN-1:0]                chan_run;
    logic [NUM_CHAN-1:0]                chan_clear;
    logic [NUM_CHAN-1:0]                chan_strobe;
    logic [NUM_DAC*DAC_WIDTH-1:0]       dac_i;
    logic [NUM_DAC*DAC_WIDTH-1:0]       dac_q;
    logic                               run;

    modport master (
        output set_stb, set_addr, set_data, dac_stb, chan_sample, chan_run, chan_clear,
        input  chan_strobe, dac_i, dac_q, run
    );

    modport slave (
        input  set_stb, set_addr, set_data, dac_stb, chan_sample, chan_run, chan_clear,
        output chan_strobe, dac_i, dac_q, run
    );
endinterface

// File: rtl/umtrx_tx_dac_mux.sv
// TX sample distributor: divided DAC strobe -> per-channel consume strobes, capture, width conversion, crossbar to DACs.
// Latency: chan_strobe at S -> dac outputs at S+3; no backpressure, samples are pulled on the divided DAC strobe.
module umtrx_tx_dac_mux #(
    parameter int NUM_CHAN   = 2,
    parameter int NUM_DAC    = 2,
    parameter int SAMP_WIDTH = 16,
    parameter int DAC_WIDTH  = 12,
    parameter int BASE       = 0
) (
    input  logic               clk,
    input  logic               rst,
    umtrx_tx_dac_mux_if.slave  bus
);
    localparam int SHIFT = SAMP_WIDTH - DAC_WIDTH;
    localparam int RND   = (1 << SHIFT) >> 1;
    localparam logic [SAMP_WIDTH-1:0] RND_V = SAMP_WIDTH'(RND);
    localparam logic [DAC_WIDTH-1:0]  SAT_V = {1'b0, {(DAC_WIDTH-1){1'b1}}};

    function automatic logic [DAC_WIDTH-1:0] convert(input logic [SAMP_WIDTH-1:0] x, input logic rnd);
        logic [SAMP_WIDTH-1:0] sum;
        sum = x + RND_V;
        if (rnd && (SHIFT > 0)) begin
            // only a positive input can wrap into the sign bit after adding the half-LSB
            if (!x[SAMP_WIDTH-1] && sum[SAMP_WIDTH-1])
                return SAT_V;
            return sum[SAMP_WIDTH-1 -: DAC_WIDTH];
        end
        return x[SAMP_WIDTH-1 -: DAC_WIDTH];
    endfunction

    logic                        run_any, wr_sel, wr_ctrl, tick;
    logic [7:0]                  cnt_q, cnt_d, cnt_eff, div_q, div_eff;
    logic                        round_q, idle_q, run_q;
    logic [NUM_DAC-1:0]          swap_q;
    logic [3:0]                  sel_q    [NUM_DAC];
    logic [NUM_CHAN-1:0]         cstb_q;
    logic [2*SAMP_WIDTH-1:0]     hold_q   [NUM_CHAN];
    logic [2*SAMP_WIDTH-1:0]     hold_d   [NUM_CHAN];
    logic [DAC_WIDTH-1:0]        conv_i_q [NUM_DAC];
    logic [DAC_WIDTH-1:0]        conv_q_q [NUM_DAC];
    logic [DAC_WIDTH-1:0]        conv_i_d [NUM_DAC];
    logic [DAC_WIDTH-1:0]        conv_q_d [NUM_DAC];
    logic [DAC_WIDTH-1:0]        dac_i_q  [NUM_DAC];
    logic [DAC_WIDTH-1:0]        dac_q_q  [NUM_DAC];
    logic                        unused_set_data;

    assign run_any = |bus.chan_run;
    assign wr_sel  = bus.set_stb && (bus.set_addr == 8'(BASE));
    assign wr_ctrl = bus.set_stb && (bus.set_addr == 8'(BASE + 1));
    assign unused_set_data = ^bus.set_data[31:10];

    // A CTRL write restarts the count and the coincident strobe already uses the new divisor
    always_comb begin
        cnt_eff = wr_ctrl ? 8'd0 : cnt_q;
        div_eff = wr_ctrl ? bus.set_data[7:0] : div_q;
        tick    = 1'b0;
        cnt_d   = cnt_eff;
        if (!run_any) begin
            cnt_d = 8'd0;
        end else if (bus.dac_stb) begin
            if (cnt_eff == div_eff) begin
                tick  = 1'b1;
                cnt_d = 8'd0;
            end else begin
                cnt_d = cnt_eff + 8'd1;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CHAN; c++) begin
            hold_d[c] = hold_q[c];
            if (bus.chan_clear[c])
                hold_d[c] = '0;
            else if (cstb_q[c])
                hold_d[c] = bus.chan_sample[c*2*SAMP_WIDTH +: 2*SAMP_WIDTH];
            else if (!bus.chan_run[c] && !idle_q)
                hold_d[c] = '0;
        end
    end

    // Out-of-range selects match no channel and leave the DAC at zero
    always_comb begin
        for (int d = 0; d < NUM_DAC; d++) begin
            conv_i_d[d] = '0;
            conv_q_d[d] = '0;
            for (int c = 0; c < NUM_CHAN; c++) begin
                if (sel_q[d] == 4'(c)) begin
                    conv_i_d[d] = convert(hold_q[c][2*SAMP_WIDTH-1 -: SAMP_WIDTH], round_q);
                    conv_q_d[d] = convert(hold_q[c][SAMP_WIDTH-1:0], round_q);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            div_q   <= '0;
            round_q <= 1'b0;
            idle_q  <= 1'b0;
            swap_q  <= '0;
            run_q   <= 1'b0;
            cstb_q  <= '0;
            for (int c = 0; c < NUM_CHAN; c++)
                hold_q[c] <= '0;
            for (int d = 0; d < NUM_DAC; d++) begin
                sel_q[d]    <= 4'(d % NUM_CHAN);
                conv_i_q[d] <= '0;
                conv_q_q[d] <= '0;
                dac_i_q[d]  <= '0;
                dac_q_q[d]  <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            run_q  <= run_any;
            cstb_q <= tick ? bus.chan_run : '0;
            hold_q <= hold_d;
            for (int d = 0; d < NUM_DAC; d++) begin
                conv_i_q[d] <= conv_i_d[d];
                conv_q_q[d] <= conv_q_d[d];
                dac_i_q[d]  <= swap_q[d] ? conv_q_q[d] : conv_i_q[d];
                dac_q_q[d]  <= swap_q[d] ? conv_i_q[d] : conv_q_q[d];
                if (wr_sel)
                    sel_q[d] <= bus.set_data[4*d +: 4];
            end
            if (wr_ctrl) begin
                div_q   <= bus.set_data[7:0];
                round_q <= bus.set_data[8];
                idle_q  <= bus.set_data[9];
                swap_q  <= bus.set_data[10 +: NUM_DAC];
            end
        end
    end

    assign bus.chan_strobe = cstb_q;
    assign bus.run         = run_q;

    for (genvar g = 0; g < NUM_DAC; g++) begin : g_out
        assign bus.dac_i[g*DAC_WIDTH +: DAC_WIDTH] = dac_i_q[g];
        assign bus.dac_q[g*DAC_WIDTH +: DAC_WIDTH] = dac_q_q[g];
    end
endmodule

// File: tb/tb_umtrx_tx_dac_mux.sv
// Bench for umtrx_tx_dac_mux: strobe-count/history reference model checked every cycle, plus directed literal expectations.
module tb_umtrx_tx_dac_mux;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    umtrx_tx_dac_mux_if #(.NUM_CHAN(2), .NUM_DAC(2), .SAMP_WIDTH(16), .DAC_WIDTH(12)) bus ();

    umtrx_tx_dac_mux #(.NUM_CHAN(2), .NUM_DAC(2), .SAMP_WIDTH(16), .DAC_WIDTH(12), .BASE(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: signed value scaled by 1/16, floor for truncation, half-up for rounding, clamped
    function automatic logic [11:0] conv(input logic [15:0] x, input bit rnd);
        int v, r;
        v = int'($signed(x));
        r = rnd ? ((v + 8) >>> 4) : (v >>> 4);
        if (r > 2047) r = 2047;
        return 12'(r);
    endfunction

    // Model state visible in the current cycle, plus snapshots of the two previous cycles
    logic [31:0] m_hold [2];
    logic [31:0] h1_hold [2];
    logic [31:0] h2_hold [2];
    logic [3:0]  m_sel [2];
    logic [3:0]  h1_sel [2];
    logic [3:0]  h2_sel [2];
    bit          m_round, h1_round, h2_round, m_idle;
    logic [1:0]  m_swap, h1_swap;
    logic [1:0]  m_cs;
    bit          m_run;
    int          m_div, m_n;
    bit          r1 = 1'b1, r2 = 1'b1;
    bit          tk;

    always @(posedge clk) begin
        h2_hold = h1_hold; h2_sel = h1_sel; h2_round = h1_round;
        h1_hold = m_hold;  h1_sel = m_sel;  h1_round = m_round; h1_swap = m_swap;
        r2 = r1; r1 = rst;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin m_hold[i] = '0; m_sel[i] = 4'(i); end
            m_round = 0; m_idle = 0; m_swap = '0; m_cs = '0; m_run = 0; m_div = 0; m_n = 0;
        end else begin
            tk = 0;
            if (bus.set_stb && bus.set_addr == 8'd1) begin m_n = 0; m_div = int'(bus.set_data[7:0]); end
            if (bus.chan_run == 2'b00) m_n = 0;
            else if (bus.dac_stb) begin
                tk = ((m_n % (m_div + 1)) == m_div);
                m_n++;
            end
            for (int c = 0; c < 2; c++) begin
                if (bus.chan_clear[c]) m_hold[c] = '0;
                else if (m_cs[c]) m_hold[c] = bus.chan_sample[c*32 +: 32];
                else if (!bus.chan_run[c] && !m_idle) m_hold[c] = '0;
            end
            m_cs  = tk ? bus.chan_run : 2'b00;
            m_run = |bus.chan_run;
            if (bus.set_stb && bus.set_addr == 8'd0)
                for (int d = 0; d < 2; d++) m_sel[d] = bus.set_data[4*d +: 4];
            if (bus.set_stb && bus.set_addr == 8'd1) begin
                m_round = bus.set_data[8]; m_idle = bus.set_data[9]; m_swap = bus.set_data[11:10];
            end
        end
    end

    logic [11:0] e_i, e_q, e_t;
    always @(negedge clk) begin
        if (checking) begin
            chk("chan_strobe", 32'(bus.chan_strobe), 32'(m_cs));
            chk("run", 32'(bus.run), 32'(m_run));
            for (int d = 0; d < 2; d++) begin
                e_i = '0; e_q = '0;
                if (!r1 && !r2 && h2_sel[d] < 4'd2) begin
                    e_i = conv(h2_hold[h2_sel[d][0]][31:16], h2_round);
                    e_q = conv(h2_hold[h2_sel[d][0]][15:0], h2_round);
                    if (h1_swap[d]) begin e_t = e_i; e_i = e_q; e_q = e_t; end
                end
                chk($sformatf("model dac_i[%0d]", d), 32'(bus.dac_i[d*12 +: 12]), 32'(e_i));
                chk($sformatf("model dac_q[%0d]", d), 32'(bus.dac_q[d*12 +: 12]), 32'(e_q));
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus.set_stb = 1'b1; bus.set_addr = a; bus.set_data = d;
        step();
        bus.set_stb = 1'b0;
    endtask

    task automatic samp(input int c, input logic [15:0] i, input logic [15:0] q);
        bus.chan_sample[c*32 +: 32] = {i, q};
    endtask

    // One DAC strobe, then land on the negedge of the cycle the captured sample reaches the DACs
    task automatic pulse_wait();
        bus.dac_stb = 1'b1;
        step();
        bus.dac_stb = 1'b0;
        steps(3);
        @(negedge clk);
    endtask

    task automatic chk_dacs(input string name, input logic [11:0] i0, input logic [11:0] q0,
                            input logic [11:0] i1, input logic [11:0] q1);
        chk({name, " dac_i0"}, 32'(bus.dac_i[11:0]),  32'(i0));
        chk({name, " dac_q0"}, 32'(bus.dac_q[11:0]),  32'(q0));
        chk({name, " dac_i1"}, 32'(bus.dac_i[23:12]), 32'(i1));
        chk({name, " dac_q1"}, 32'(bus.dac_q[23:12]), 32'(q1));
    endtask

    initial begin
        rst = 1'b1;
        bus.set_stb = 0; bus.set_addr = '0; bus.set_data = '0; bus.dac_stb = 0;
        bus.chan_sample = '0; bus.chan_run = '0; bus.chan_clear = '0;
        step();
        checking = 1'b1;
        steps(2);
        @(negedge clk);
        chk_dacs("reset", 12'h0, 12'h0, 12'h0, 12'h0);
        chk("reset chan_strobe", 32'(bus.chan_strobe), 32'h0);
        chk("reset run", 32'(bus.run), 32'h0);
        rst = 1'b0;

        // Default config, every DAC strobe passes through
        samp(0, 16'h1234, 16'h0ABC); samp(1, 16'h5678, 16'h4321);
        bus.chan_run = 2'b11;
        steps(2);
        repeat (3) begin
            bus.dac_stb = 1'b1;
            step();
            bus.dac_stb = 1'b0;
            @(negedge clk) chk("t1 chan_strobe", 32'(bus.chan_strobe), 32'h3);
            steps(3);
            @(negedge clk) chk_dacs("t1", 12'h123, 12'h0AB, 12'h567, 12'h432);
        end

        // DIV=3 with continuous strobe; each CTRL write restarts the count
        bus.dac_stb = 1'b1;
        repeat (2) begin
            wr(8'd1, 32'd3);
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk) chk($sformatf("t2 chan_strobe +%0d", k), 32'(bus.chan_strobe), (k == 4) ? 32'h3 : 32'h0);
                step();
            end
            steps(4);
        end
        bus.dac_stb = 1'b0;
        wr(8'd1, 32'd0);
        steps(2);

        // Rounding with saturation, then truncation
        wr(8'd1, 32'h100);
        samp(0, 16'h7FF8, 16'h1238); samp(1, 16'hFFF8, 16'h8008);
        pulse_wait();
        chk_dacs("round", 12'h7FF, 12'h124, 12'h000, 12'h801);
        wr(8'd1, 32'h0);
        samp(0, 16'h1238, 16'h1238);
        pulse_wait();
        chk_dacs("trunc", 12'h123, 12'h123, 12'hFFF, 12'h800);

        // Both DACs from ch0, DAC1 swapped; then DAC1 pointed at a nonexistent channel
        samp(0, 16'h1234, 16'h0ABC);
        wr(8'd0, 32'h00);
        wr(8'd1, 32'h800);
        pulse_wait();
        chk_dacs("swap", 12'h123, 12'h0AB, 12'h0AB, 12'h123);
        wr(8'd0, 32'hF0);
        steps(2);
        @(negedge clk) chk_dacs("sel_oob", 12'h123, 12'h0AB, 12'h000, 12'h000);

        // ch1 stops with IDLE_HOLD=0: forced to zero, no more strobes
        wr(8'd0, 32'h10);
        wr(8'd1, 32'h0);
        samp(1, 16'h5678, 16'h4321);
        pulse_wait();
        chk("idle pre dac_i1", 32'(bus.dac_i[23:12]), 32'h567);
        bus.chan_run = 2'b01;
        steps(3);
        @(negedge clk) chk_dacs("idle0", 12'h123, 12'h0AB, 12'h000, 12'h000);
        bus.dac_stb = 1'b1;
        step();
        bus.dac_stb = 1'b0;
        @(negedge clk) chk("idle0 chan_strobe", 32'(bus.chan_strobe), 32'h1);

        // IDLE_HOLD=1 keeps the last ch1 sample
        bus.chan_run = 2'b11;
        samp(1, 16'h1357, 16'h2468);
        pulse_wait();
        wr(8'd1, 32'h200);
        bus.chan_run = 2'b01;
        steps(5);
        @(negedge clk) chk_dacs("idle1", 12'h123, 12'h0AB, 12'h135, 12'h246);

        // Clear on ch0 in its strobe cycle wins over capture
        bus.chan_run = 2'b11;
        samp(0, 16'h1111, 16'h2222);
        bus.dac_stb = 1'b1;
        step();
        bus.dac_stb = 1'b0;
        bus.chan_clear = 2'b01;
        step();
        bus.chan_clear = 2'b00;
        steps(2);
        @(negedge clk) chk_dacs("clear", 12'h000, 12'h000, 12'h135, 12'h246);

        // Reset while streaming under a non-default config
        wr(8'd1, 32'h803);
        wr(8'd0, 32'h01);
        bus.dac_stb = 1'b1;
        steps(6);
        rst = 1'b1;
        step();
        @(negedge clk);
        chk_dacs("rst mid", 12'h0, 12'h0, 12'h0, 12'h0);
        chk("rst mid chan_strobe", 32'(bus.chan_strobe), 32'h0);
        chk("rst mid run", 32'(bus.run), 32'h0);
        rst = 1'b0;
        bus.chan_run = 2'b00;
        steps(4);
        bus.dac_stb = 1'b0;
        samp(0, 16'h1234, 16'h0ABC); samp(1, 16'h5678, 16'h4321);
        bus.chan_run = 2'b11;
        step();
        bus.dac_stb = 1'b1;
        step();
        bus.dac_stb = 1'b0;
        @(negedge clk) chk("post rst chan_strobe", 32'(bus.chan_strobe), 32'h3);
        steps(3);
        @(negedge clk) chk_dacs("post rst", 12'h123, 12'h0AB, 12'h567, 12'h432);

        steps(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
